// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one memory port between I-cache fills and D-cache fills/writebacks.
// Optional macro CACHE_ARBITER_RR_EN breaks simultaneous requests round-robin instead of favouring D.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              d_req;
  logic              grant_d;

  assign d_req = d_read | d_write;

`ifdef CACHE_ARBITER_RR_EN
  // last_d_q = 1 when D won the most recent grant; a tie goes to the other side
  logic last_d_q;

  assign grant_d = d_req & (~i_read | ~last_d_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if ((state == IDLE) && (d_req || i_read)) begin
      last_d_q <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = D_BUSY;
        end else if (i_read) begin
          state_next = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the winner's command on grant so requester changes mid-transaction are invisible
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && (state_next != IDLE)) begin
        addr_q  <= grant_d ? d_address : i_address;
        write_q <= grant_d & d_write;
        if (grant_d && d_write) begin
          wdata_q <= d_wdata;
        end
      end
    end
  end

  always_comb begin
    mem_read    = (state != IDLE) & ~write_q;
    mem_write   = (state != IDLE) & write_q;
    mem_address = addr_q;
    mem_wdata   = wdata_q;
    i_resp      = (state == I_BUSY) & mem_resp;
    d_resp      = (state == D_BUSY) & mem_resp;
    i_rdata     = mem_rdata;
    d_rdata     = mem_rdata;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios plus randomized traffic, checked cycle by cycle against
// a transaction-level reference model (honours CACHE_ARBITER_RR_EN like the design).
module tb_cache_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction, who owns it, and what was captured at grant
  bit                m_busy;
  bit                m_owner_d;
  bit                m_write;
  bit                m_last_d;
  bit                m_after_reset;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  int                mem_delay;
  int                forced_delay = -1;
  bit                use_pat = 1'b0;
  logic [LINE_W-1:0] pat;
  bit                i_done;
  bit                d_done;

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] actual,
                             input logic [LINE_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [ADDR_W-1:0] randAddr();
    logic [ADDR_W-1:0] a;
    a = $urandom();
    return a & ~32'h1F;
  endfunction

  function automatic logic [LINE_W-1:0] randLine();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // One clock: drive memory side, check outputs mid-cycle, advance model at the edge
  task automatic runCycle(input bit stray);
    logic [LINE_W-1:0] rd;
    bit exp_i, exp_d, grant_d, d_req;
    mem_resp  = m_busy ? (mem_delay == 0) : stray;
    rd        = use_pat ? pat : randLine();
    mem_rdata = rd;
    #1;
    exp_i = m_busy && !m_owner_d && mem_resp;
    exp_d = m_busy && m_owner_d && mem_resp;
    checkOutput("mem_read", mem_read, m_busy && !m_write);
    checkOutput("mem_write", mem_write, m_busy && m_write);
    checkOutput("i_resp", i_resp, exp_i);
    checkOutput("d_resp", d_resp, exp_d);
    if (m_busy || m_after_reset) checkOutput("mem_address", mem_address, m_addr);
    if (m_busy && m_write) checkOutput("mem_wdata", mem_wdata, m_wdata);
    if (exp_i) checkOutput("i_rdata", i_rdata, rd);
    if (exp_d) checkOutput("d_rdata", d_rdata, rd);
    i_done = exp_i;
    d_done = exp_d;
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_write = 0; m_addr = '0; m_wdata = '0; m_last_d = 0; m_after_reset = 1;
    end else begin
      m_after_reset = 0;
      if (m_busy) begin
        if (mem_resp) m_busy = 0;
        else mem_delay--;
      end else begin
        d_req = d_read || d_write;
        if (d_req || i_read) begin
`ifdef CACHE_ARBITER_RR_EN
          grant_d = d_req && (!i_read || !m_last_d);
`else
          grant_d = d_req;
`endif
          m_busy    = 1;
          m_owner_d = grant_d;
          m_last_d  = grant_d;
          m_addr    = grant_d ? d_address : i_address;
          m_write   = grant_d && d_write;
          if (m_write) m_wdata = d_wdata;
          mem_delay = (forced_delay >= 0) ? forced_delay : $urandom_range(0, 3);
        end
      end
    end
    @(negedge clk);
    if (i_done) i_read = 0;
    if (d_done) begin d_read = 0; d_write = 0; end
  endtask

  // Randomized requester behaviour: new requests, occasional drops, mid-transaction scribbles
  task automatic applyStimulus();
    int op;
    rst_n = ($urandom_range(0, 59) != 0);
    if (!i_read) begin
      if ($urandom_range(0, 2) == 0) begin i_read = 1; i_address = randAddr(); end
    end else if (m_busy && !m_owner_d) begin
      if ($urandom_range(0, 3) == 0) i_address = randAddr();
    end else if ($urandom_range(0, 19) == 0) i_read = 0;
    if (!(d_read || d_write)) begin
      if ($urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 2);
        d_read = (op != 1); d_write = (op != 0);
        d_address = randAddr(); d_wdata = randLine();
      end
    end else if (m_busy && m_owner_d) begin
      if ($urandom_range(0, 3) == 0) begin d_address = randAddr(); d_wdata = randLine(); end
    end else if ($urandom_range(0, 19) == 0) begin
      d_read = 0; d_write = 0;
    end
    runCycle($urandom_range(0, 3) == 0);
  endtask

  task automatic waitDone(input string tag, input bit for_d, input int budget);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      runCycle(0);
      seen = for_d ? d_done : i_done;
    end
    checkOutput(tag, seen, 1'b1);
  endtask

  // Issue a simultaneous I/D read pair and report which side completed first (1 = D)
  task automatic tieRound(output int first_d);
    first_d = -1;
    i_read = 1; i_address = 32'h400; d_read = 1; d_address = 32'h500;
    for (int n = 0; n < 30 && (i_read || d_read); n++) begin
      runCycle(0);
      if (first_d < 0 && d_done) first_d = 1;
      if (first_d < 0 && i_done) first_d = 0;
    end
  endtask

  initial begin
    int first_d;
    bit d_seen;
    rst_n = 0; i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_resp = 0; mem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    m_busy = 0; m_write = 0; m_addr = '0; m_wdata = '0; m_last_d = 0; m_after_reset = 1;
    runCycle(1);
    rst_n = 1;
    runCycle(0);

    // Scenario 1: I fill, memory answers three cycles after mem_read rises
    use_pat = 1; pat = {(LINE_W / 8){8'hAA}}; forced_delay = 3;
    i_read = 1; i_address = 32'h60;
    waitDone("s1_i_resp", 0, 10);
    use_pat = 0; forced_delay = -1;
    runCycle(0);

    // Scenario 2: D writeback
    d_write = 1; d_address = 32'h100; d_wdata = {(LINE_W / 8){8'h55}};
    waitDone("s2_d_resp", 1, 10);

    // Scenario 3: ties from a fresh reset go D, then I, and the next tie goes D
    rst_n = 0; runCycle(0); rst_n = 1;
    tieRound(first_d);
    checkOutput("s3_first_tie_d", first_d, 1);
    checkOutput("s3_both_served", {i_read, d_read}, 2'b00);
    tieRound(first_d);
    checkOutput("s3_second_tie_d", first_d, 1);

    // Scenario 4: address scribbled after grant must not reach memory
    forced_delay = 3;
    d_read = 1; d_address = 32'h200;
    runCycle(0);
    d_address = 32'h300;
    waitDone("s4_d_resp", 1, 10);
    forced_delay = -1;

    // Scenario 5: reset in D_BUSY, then a stray mem_resp produces nothing
    forced_delay = 6;
    d_read = 1; d_address = 32'h700;
    runCycle(0);
    runCycle(0);
    rst_n = 0; runCycle(0); rst_n = 1; d_read = 0;
    runCycle(1);
    d_seen = d_done;
    runCycle(1);
    checkOutput("s5_no_d_resp", d_seen | d_done, 1'b0);
    checkOutput("s5_idle_after", {mem_read, mem_write}, 2'b00);
    forced_delay = -1;

    // Scenario 6: read and write together means write only
    d_read = 1; d_write = 1; d_address = 32'h800; d_wdata = randLine();
    waitDone("s6_d_resp", 1, 10);

    for (int c = 0; c < 3000; c++) applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
